// File: rtl/dpm_pkg.sv
// Shared types for the DPM producer: FSM states, tile entry, widths.
// Imported by tile_fifo and producer_dpm.
package dpm_pkg;

  localparam int COL_W = 16;
  localparam int CNT_W = 32;
  localparam int PTR_W = COL_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] cols;
  } tile_t;

  localparam int TILE_W = $bits(tile_t);

  function automatic logic [PTR_W-1:0] min_ptr(
    input logic [PTR_W-1:0] a,
    input logic [PTR_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/producer_dpm_tile_fifo.sv
// tile_fifo: synchronous FIFO of tile entries; push+pop allowed when full.
// Ports: push/din, pop, head (0 when empty), empty, full.
module tile_fifo
  import dpm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  tile_t din,
  input  logic  pop,
  output tile_t head,
  output logic  empty,
  output logic  full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  tile_t       mem_q [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      // When full, the write slot is the head slot being popped.
      if (push) mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/producer_dpm.sv
// producer_dpm: paces tile production for one frame into a tile buffer.
// Ports: start/tile_columns in, consume_start pops; tile_avail, head_*,
// produced_count, busy, frame_done out. Option macro: PRODUCER_JITTER_EN.
module producer_dpm
  import dpm_pkg::*;
#(
  parameter int FRAME_COLS     = 64,
  parameter int BASE_PERIOD    = 20,
  parameter int JITTER         = 0,
  parameter int TILE_BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] tile_columns,
  input  logic        consume_start,
  output logic        tile_avail,
  output logic [15:0] head_col,
  output logic [15:0] head_cols,
  output logic [31:0] produced_count,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [PTR_W-1:0] FRAME_P = PTR_W'(FRAME_COLS);
  localparam logic [COL_W-1:0] FRAME_C = COL_W'(FRAME_COLS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   col_ptr_q, col_ptr_d;
  logic [COL_W-1:0]   tc_q, tc_d;
  logic [CNT_W-1:0]   prod_q, prod_d;

  logic [CNT_W-1:0]   period;
  logic [PTR_W-1:0]   cols;
  logic [PTR_W-1:0]   next_ptr;
  logic               expiry;
  logic               pop;
  logic               push;
  logic               can_push;
  tile_t              din;
  tile_t              head;
  logic               empty;
  logic               full;

`ifdef PRODUCER_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d  = push ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
  assign period  = CNT_W'(BASE_PERIOD) +
                   CNT_W'(32'(lfsr_q) % 32'(JITTER + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  // JITTER has no effect without the jitter build.
  assign period = CNT_W'(BASE_PERIOD) + CNT_W'(JITTER * 0);
`endif

  assign expiry   = (cnt_q == period - 1'b1);
  assign pop      = consume_start && !empty;
  assign can_push = !full || pop;
  assign cols     = min_ptr({1'b0, tc_q}, FRAME_P - col_ptr_q);
  assign next_ptr = col_ptr_q + cols;
  assign din      = '{col: col_ptr_q[COL_W-1:0], cols: cols[COL_W-1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_ptr_d = col_ptr_q;
    tc_d      = tc_q;
    prod_d    = prod_q;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          col_ptr_d = '0;
          if (tile_columns == '0)
            tc_d = 16'd1;
          else if ({1'b0, tile_columns} > FRAME_P)
            tc_d = FRAME_C;
          else
            tc_d = tile_columns;
        end
      end
      RUN, STALL: begin
        if (state_q == RUN && !expiry) begin
          cnt_d = cnt_q + 1'b1;
        end else if (can_push) begin
          push      = 1'b1;
          cnt_d     = '0;
          col_ptr_d = next_ptr;
          prod_d    = prod_q + 1'b1;
          state_d   = (next_ptr >= FRAME_P) ? DRAIN : RUN;
        end else begin
          // Expired against a full buffer: hold the count and wait.
          state_d = STALL;
        end
      end
      DRAIN: begin
        if (empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      col_ptr_q <= '0;
      tc_q      <= '0;
      prod_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_ptr_q <= col_ptr_d;
      tc_q      <= tc_d;
      prod_q    <= prod_d;
    end
  end

  tile_fifo #(
    .DEPTH(TILE_BUF_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (din),
    .pop  (pop),
    .head (head),
    .empty(empty),
    .full (full)
  );

  assign tile_avail     = !empty;
  assign head_col       = head.col;
  assign head_cols      = head.cols;
  assign produced_count = prod_q;
  assign busy           = (state_q != IDLE);
  assign frame_done     = (state_q == DRAIN) && empty;

endmodule
